dom1_skinny_rnd_ctrl: RTL and testbench

- Sequencing and state-register stage that sits directly upstream of the DOM-1 Skinny-128-384+ round datapath.
- Holds the two masked state shares and drives them to the round datapath as sshi0/sshi1.
- Generates the one-hot four-layer S-box enable en[3:0], gating each layer on the availability of fresh randomness.
- Captures the round output shares back into the state registers, counts ROUNDS rounds, and exposes the round index and step pulse to the tweakey-share schedule.

---
 rtl/dom1_skinny_pkg.sv | 18 +
 rtl/dom1_skinny_rnd_ctrl_if.sv | 37 +++
 rtl/dom1_skinny_phase_seq.sv | 93 +++++++++
 rtl/dom1_skinny_rnd_ctrl.sv | 117 +++++++++++
 tb/tb_dom1_skinny_rnd_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dom1_skinny_pkg.sv
// Shared types and constants for the DOM-1 Skinny-128-384+ round controller.
package dom1_skinny_pkg;

  localparam int SKINNY_ROUNDS = 40;
  localparam int SKINNY_LAYERS = 4;
  localparam int SHARE_W       = 128;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    L0   = 3'd1,
    L1   = 3'd2,
    L2   = 3'd3,
    L3   = 3'd4,
    CAP  = 3'd5,
    DONE = 3'd6
  } phase_e;

endpackage

// File: rtl/dom1_skinny_rnd_ctrl_if.sv
// Bus between the round controller (slave) and its environment (master):
// host start/plaintext, randomness handshake, round datapath shares,
// tweakey-schedule strobes and ciphertext.
interface dom1_skinny_rnd_ctrl_if
  import dom1_skinny_pkg::*;
#(
  parameter int RW = 6
);

  logic                     start;
  logic [SHARE_W-1:0]       pt0;
  logic [SHARE_W-1:0]       pt1;
  logic                     rnd_vld;
  logic                     rnd_req;
  logic [SKINNY_LAYERS-1:0] en;
  logic [SHARE_W-1:0]       sshi0;
  logic [SHARE_W-1:0]       sshi1;
  logic [SHARE_W-1:0]       ssho0;
  logic [SHARE_W-1:0]       ssho1;
  logic [RW-1:0]            rnd_idx;
  logic                     tk_nxt;
  logic                     busy;
  logic                     done;
  logic [SHARE_W-1:0]       ct0;
  logic [SHARE_W-1:0]       ct1;

  modport master (
    output start, pt0, pt1, rnd_vld, ssho0, ssho1,
    input  rnd_req, en, sshi0, sshi1, rnd_idx, tk_nxt, busy, done, ct0, ct1
  );

  modport slave (
    input  start, pt0, pt1, rnd_vld, ssho0, ssho1,
    output rnd_req, en, sshi0, sshi1, rnd_idx, tk_nxt, busy, done, ct0, ct1
  );

endinterface

// File: rtl/dom1_skinny_phase_seq.sv
// Phase sequencer: walks IDLE -> L0..L3 -> CAP per round, stalls each
// S-box layer until fresh randomness is valid, decodes the one-hot layer
// enable and counts rounds.
module dom1_skinny_phase_seq
  import dom1_skinny_pkg::*;
#(
  parameter int ROUNDS = SKINNY_ROUNDS,
  parameter int RW     = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     rnd_vld,
  output phase_e                   phase,
  output logic [SKINNY_LAYERS-1:0] en,
  output logic                     rnd_req,
  output logic [RW-1:0]            rnd_idx,
  output logic                     cap,
  output logic                     last
);

  localparam logic [RW-1:0] LAST_IDX = RW'(ROUNDS - 1);

  phase_e        phase_q, phase_d;
  logic [RW-1:0] rnd_idx_q, rnd_idx_d;

  // Phase and round-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= IDLE;
      rnd_idx_q <= '0;
    end else begin
      phase_q   <= phase_d;
      rnd_idx_q <= rnd_idx_d;
    end
  end

  // Next phase, layer enables gated by rnd_vld, and round-counter update.
  always_comb begin
    phase_d   = phase_q;
    rnd_idx_d = rnd_idx_q;
    en        = '0;
    rnd_req   = 1'b0;
    unique case (phase_q)
      IDLE: begin
        if (start) begin
          phase_d   = L0;
          rnd_idx_d = '0;
        end
      end
      L0: begin
        rnd_req = 1'b1;
        en[0]   = rnd_vld;
        if (rnd_vld) phase_d = L1;
      end
      L1: begin
        rnd_req = 1'b1;
        en[1]   = rnd_vld;
        if (rnd_vld) phase_d = L2;
      end
      L2: begin
        rnd_req = 1'b1;
        en[2]   = rnd_vld;
        if (rnd_vld) phase_d = L3;
      end
      L3: begin
        rnd_req = 1'b1;
        en[3]   = rnd_vld;
        if (rnd_vld) phase_d = CAP;
      end
      CAP: begin
        if (rnd_idx_q == LAST_IDX) begin
          phase_d = DONE;
        end else begin
          rnd_idx_d = rnd_idx_q + RW'(1);
          phase_d   = L0;
        end
      end
      DONE: begin
        phase_d = IDLE;
      end
      default: begin
        phase_d = IDLE;
      end
    endcase
  end

  assign phase   = phase_q;
  assign rnd_idx = rnd_idx_q;
  assign cap     = (phase_q == CAP);
  assign last    = (rnd_idx_q == LAST_IDX);

endmodule

// File: rtl/dom1_skinny_rnd_ctrl.sv
// DOM-1 Skinny-128-384+ round controller: holds the two state shares,
// feeds them to the round datapath and captures its output once per round.
// Shares are kept strictly separate; they are never combined here.
// Optional build macro DOM1_SKINNY_ZEROIZE_EN: ciphertext is copied into a
// dedicated hold register at DONE and the state shares are wiped on the
// return to IDLE, so the datapath inputs read zero while idle.
module dom1_skinny_rnd_ctrl
  import dom1_skinny_pkg::*;
#(
  parameter int ROUNDS = SKINNY_ROUNDS,
  parameter int RW     = 6
) (
  input logic                   clk,
  input logic                   rst,
  dom1_skinny_rnd_ctrl_if.slave bus
);

  phase_e                   phase;
  logic [SKINNY_LAYERS-1:0] en;
  logic                     rnd_req;
  logic [RW-1:0]            rnd_idx;
  logic                     cap;
  logic                     last;
  logic                     load;
  logic [SHARE_W-1:0]       state0_q, state0_d;
  logic [SHARE_W-1:0]       state1_q, state1_d;

  dom1_skinny_phase_seq #(
    .ROUNDS (ROUNDS),
    .RW     (RW)
  ) u_seq (
    .clk     (clk),
    .rst     (rst),
    .start   (bus.start),
    .rnd_vld (bus.rnd_vld),
    .phase   (phase),
    .en      (en),
    .rnd_req (rnd_req),
    .rnd_idx (rnd_idx),
    .cap     (cap),
    .last    (last)
  );

  assign load = (phase == IDLE) && bus.start;

  // State shares: load plaintext on start, capture datapath output at CAP.
  always_comb begin
    state0_d = state0_q;
    state1_d = state1_q;
    if (load) begin
      state0_d = bus.pt0;
      state1_d = bus.pt1;
    end else if (cap) begin
      state0_d = bus.ssho0;
      state1_d = bus.ssho1;
    end
`ifdef DOM1_SKINNY_ZEROIZE_EN
    else if (phase == DONE) begin
      state0_d = '0;
      state1_d = '0;
    end
`endif
  end

  // State share registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state0_q <= '0;
      state1_q <= '0;
    end else begin
      state0_q <= state0_d;
      state1_q <= state1_d;
    end
  end

`ifdef DOM1_SKINNY_ZEROIZE_EN
  logic [SHARE_W-1:0] ct0_q, ct0_d;
  logic [SHARE_W-1:0] ct1_q, ct1_d;

  // Ciphertext hold: snapshot the final state during DONE.
  always_comb begin
    ct0_d = ct0_q;
    ct1_d = ct1_q;
    if (phase == DONE) begin
      ct0_d = state0_q;
      ct1_d = state1_q;
    end
  end

  // Ciphertext hold registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct0_q <= '0;
      ct1_q <= '0;
    end else begin
      ct0_q <= ct0_d;
      ct1_q <= ct1_d;
    end
  end

  assign bus.ct0 = ct0_q;
  assign bus.ct1 = ct1_q;
`else
  assign bus.ct0 = state0_q;
  assign bus.ct1 = state1_q;
`endif

  assign bus.sshi0   = state0_q;
  assign bus.sshi1   = state1_q;
  assign bus.en      = en;
  assign bus.rnd_req = rnd_req;
  assign bus.rnd_idx = rnd_idx;
  assign bus.tk_nxt  = cap;
  assign bus.busy    = (phase != IDLE) && (phase != DONE);
  assign bus.done    = (phase == DONE) && last;

endmodule

// File: tb/tb_dom1_skinny_rnd_ctrl.sv
// Testbench for dom1_skinny_rnd_ctrl. A stand-in round datapath (share-wise
// rotate plus round constant on share 0) closes the loop so the ciphertext
// shares can be predicted from a small golden model.
module tb_dom1_skinny_rnd_ctrl;
  import dom1_skinny_pkg::*;

  localparam int RW      = 6;
  localparam int ROUNDS  = 40;
  localparam int MAX_CYC = 400;

  typedef struct {
    logic [127:0] pt;
    logic [127:0] mask;
    int           sa_r;
    int           sa_l;
    int           sb_r;
    int           sb_l;
    bit           noise;
    int           ab_r;
    int           ab_l;
    int           exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  vec_t tbl [6];

  always #5 clk = ~clk;

  dom1_skinny_rnd_ctrl_if #(.RW(RW)) bus ();

  dom1_skinny_rnd_ctrl #(
    .ROUNDS (ROUNDS),
    .RW     (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [127:0] rotl7(input logic [127:0] x);
    return {x[120:0], x[127:121]};
  endfunction

  function automatic logic [127:0] rc(input logic [RW-1:0] k);
    return {k, 116'h0, k};
  endfunction

  // Stand-in round datapath, one transform per share.
  assign bus.ssho0 = rotl7(bus.sshi0) ^ rc(bus.rnd_idx);
  assign bus.ssho1 = rotl7(bus.sshi1);

  // Golden model of ROUNDS rounds applied to one share.
  function automatic logic [127:0] modelShare(input logic [127:0] s_in, input bit with_rc);
    logic [127:0] s;
    s = s_in;
    for (int k = 0; k < ROUNDS; k++) begin
      s = rotl7(s);
      if (with_rc) s = s ^ rc(RW'(k));
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic [127:0] p0, input logic [127:0] p1);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.pt0     = p0;
    bus.pt1     = p1;
    bus.rnd_vld = 1'b1;
    #1;
    checkOutput("busy_before_start", bus.busy, 0);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, bus.busy, 0);
    checkOutput({tag, "_en"}, bus.en, 0);
    checkOutput({tag, "_idx"}, bus.rnd_idx, 0);
    checkOutput({tag, "_sshi0"}, bus.sshi0, 0);
    checkOutput({tag, "_sshi1"}, bus.sshi1, 0);
    checkOutput({tag, "_done"}, bus.done, 0);
    checkOutput({tag, "_tk"}, bus.tk_nxt, 0);
    checkOutput({tag, "_req"}, bus.rnd_req, 0);
  endtask

  task automatic runVector(input vec_t v);
    int           r, l, stall_cnt, tk_cnt, done_cyc;
    bit           vld, finished;
    logic [3:0]   exp_en;
    logic [127:0] g0, g1, gx;
    g0 = modelShare(v.pt ^ v.mask, 1'b1);
    g1 = modelShare(v.mask, 1'b0);
    gx = modelShare(v.pt, 1'b1);
    r = 0; l = 0; stall_cnt = 0; tk_cnt = 0; done_cyc = -1; finished = 1'b0;
    applyStimulus(v.pt ^ v.mask, v.mask);
    for (int n = 1; n <= MAX_CYC && !finished; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      vld = 1'b1;
      if (l < 4 && stall_cnt < 3 &&
          ((r == v.sa_r && l == v.sa_l) || (r == v.sb_r && l == v.sb_l)))
        vld = 1'b0;
      bus.rnd_vld = vld;
      if (v.noise && ((r == 10 && l == 2) || l == 5)) begin
        bus.start = 1'b1;
        bus.pt0   = ~v.pt;
        bus.pt1   = v.pt;
      end
      if (r == v.ab_r && l == v.ab_l) begin
        rst = 1'b1;
        #1;
        checkResetOutputs("abort_now");
        @(posedge clk);
        #1;
        checkResetOutputs("abort_next");
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkResetOutputs("abort_release");
        finished = 1'b1;
      end else begin
        #1;
        exp_en = (l < 4 && vld) ? (4'b0001 << l) : 4'b0000;
        checkOutput("en", bus.en, exp_en);
        checkOutput("rnd_req", bus.rnd_req, (l < 4) ? 1 : 0);
        checkOutput("tk_nxt", bus.tk_nxt, (l == 4) ? 1 : 0);
        checkOutput("busy", bus.busy, (l < 5) ? 1 : 0);
        checkOutput("done", bus.done, (l == 5) ? 1 : 0);
        checkOutput("rnd_idx", bus.rnd_idx, r);
        if (bus.tk_nxt) tk_cnt++;
        if (l < 4) begin
          if (vld) begin
            l++;
            stall_cnt = 0;
          end else begin
            stall_cnt++;
          end
        end else if (l == 4) begin
          if (r == ROUNDS - 1) begin
            l = 5;
          end else begin
            r++;
            l = 0;
          end
        end else begin
`ifndef DOM1_SKINNY_ZEROIZE_EN
          checkOutput("ct0_at_done", bus.ct0, g0);
          checkOutput("ct1_at_done", bus.ct1, g1);
`endif
          done_cyc = n;
          finished = 1'b1;
        end
      end
    end
    if (v.ab_r < 0) begin
      checkOutput("done_cycle", done_cyc, v.exp_done);
      checkOutput("tk_count", tk_cnt, ROUNDS);
      @(negedge clk);
      bus.start   = 1'b0;
      bus.rnd_vld = 1'b0;
      #1;
      checkOutput("idle_busy", bus.busy, 0);
      checkOutput("idle_done", bus.done, 0);
      checkOutput("idle_en", bus.en, 0);
      checkOutput("ct0", bus.ct0, g0);
      checkOutput("ct1", bus.ct1, g1);
      checkOutput("ct_xor", bus.ct0 ^ bus.ct1, gx);
`ifdef DOM1_SKINNY_ZEROIZE_EN
      checkOutput("sshi0_zeroized", bus.sshi0, 0);
      checkOutput("sshi1_zeroized", bus.sshi1, 0);
`else
      checkOutput("sshi0_idle", bus.sshi0, g0);
      checkOutput("sshi1_idle", bus.sshi1, g1);
`endif
      @(negedge clk);
      #1;
      checkOutput("ct0_hold", bus.ct0, g0);
      checkOutput("ct1_hold", bus.ct1, g1);
      checkOutput("idle_idx", bus.rnd_idx, ROUNDS - 1);
    end
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset check, then the vector table.
  initial begin
    tbl[0] = '{pt: 128'h00112233_44556677_8899AABB_CCDDEEFF, mask: 128'h0,
               sa_r: -1, sa_l: -1, sb_r: -1, sb_l: -1, noise: 1'b0,
               ab_r: -1, ab_l: -1, exp_done: 201};
    tbl[1] = '{pt: 128'h00112233_44556677_8899AABB_CCDDEEFF, mask: 128'h3C5A_9E01_D2F4_7B68_A193_0E5C_4D27_B8F6,
               sa_r: -1, sa_l: -1, sb_r: -1, sb_l: -1, noise: 1'b0,
               ab_r: -1, ab_l: -1, exp_done: 201};
    tbl[2] = '{pt: 128'h00112233_44556677_8899AABB_CCDDEEFF, mask: 128'h5E1B_C047_92AD_36F8_0B7E_E4C1_58A2_6D93,
               sa_r: 5, sa_l: 1, sb_r: 39, sb_l: 3, noise: 1'b0,
               ab_r: -1, ab_l: -1, exp_done: 207};
    tbl[3] = '{pt: 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, mask: 128'h3C5A_9E01_D2F4_7B68_A193_0E5C_4D27_B8F6,
               sa_r: -1, sa_l: -1, sb_r: -1, sb_l: -1, noise: 1'b1,
               ab_r: -1, ab_l: -1, exp_done: 201};
    tbl[4] = '{pt: 128'hF0E1D2C3_B4A59687_78695A4B_3C2D1E0F, mask: 128'h5E1B_C047_92AD_36F8_0B7E_E4C1_58A2_6D93,
               sa_r: -1, sa_l: -1, sb_r: -1, sb_l: -1, noise: 1'b0,
               ab_r: 20, ab_l: 2, exp_done: -1};
    tbl[5] = '{pt: 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, mask: 128'h1111_2222_3333_4444_5555_6666_7777_8888,
               sa_r: -1, sa_l: -1, sb_r: -1, sb_l: -1, noise: 1'b0,
               ab_r: -1, ab_l: -1, exp_done: 201};

    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.pt0     = '0;
    bus.pt1     = '0;
    bus.rnd_vld = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checkResetOutputs("reset");
    checkOutput("reset_ct0", bus.ct0, 0);
    checkOutput("reset_ct1", bus.ct1, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d", i);
      runVector(tbl[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
